// File: rtl/panda_mem_arbiter_if.sv
// Shared-memory arbiter bus: fetch port, data port and memory port.
// slave is the arbiter's view; master is the core/memory side.
interface panda_mem_arbiter_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic [3:0]  data_we_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_addr_i,
    input  data_we_i, data_wdata_i,
    input  mem_gnt_i, mem_rvalid_i,
    input  mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o,
    output instr_rdata_o,
    output data_gnt_o, data_rvalid_o,
    output data_rdata_o,
    output mem_req_o, mem_addr_o,
    output mem_we_o, mem_wdata_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_addr_i,
    output data_we_i, data_wdata_i,
    output mem_gnt_i, mem_rvalid_i,
    output mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o,
    input  instr_rdata_o,
    input  data_gnt_o, data_rvalid_o,
    input  data_rdata_o,
    input  mem_req_o, mem_addr_o,
    input  mem_we_o, mem_wdata_o
  );
endinterface

// File: rtl/panda_mem_arbiter.sv
// Fetch/data arbiter for one shared memory port, one transaction
// in flight, data priority with a bounded streak against fetch.
module panda_mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input logic          clk_i,
  input logic          rst_ni,
  panda_mem_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;

  logic any_req;
  logic data_win;
  logic sel_data;
  logic req;
  logic gnt;
  logic resp;

  assign any_req  = bus.instr_req_i | bus.data_req_i;
  assign data_win = bus.data_req_i &
    ~(bus.instr_req_i & (streak_q == STREAK_MAX));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    req      = 1'b0;
    sel_data = (owner_q == OWN_DATA);
    unique case (state_q)
      IDLE: begin
        req      = any_req;
        sel_data = data_win;
        if (any_req) begin
          owner_d = data_win ? OWN_DATA : OWN_INSTR;
          state_d = bus.mem_gnt_i ? RESP : REQ;
        end
      end
      REQ: begin
        req = 1'b1;
        if (bus.mem_gnt_i) state_d = RESP;
      end
      RESP: begin
        if (bus.mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // outputs must read 0 while reset is held, even with requests up
    req = req & rst_ni;
    gnt = req & bus.mem_gnt_i;
    if (gnt) begin
      if (!sel_data || !bus.instr_req_i)
        streak_d = '0;
      else if (streak_q != STREAK_MAX)
        streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= OWN_INSTR;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  assign resp = rst_ni & (state_q == RESP) & bus.mem_rvalid_i;

  assign bus.mem_req_o   = req;
  assign bus.mem_addr_o  = !req ? '0 :
    (sel_data ? bus.data_addr_i : bus.instr_addr_i);
  assign bus.mem_we_o    = (req & sel_data) ? bus.data_we_i : '0;
  assign bus.mem_wdata_o = (req & sel_data) ? bus.data_wdata_i : '0;

  assign bus.instr_gnt_o    = gnt & ~sel_data;
  assign bus.data_gnt_o     = gnt & sel_data;
  assign bus.instr_rvalid_o = resp & (owner_q == OWN_INSTR);
  assign bus.data_rvalid_o  = resp & (owner_q == OWN_DATA);
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;

endmodule
